// File: rtl/mem_bus_router_pkg.sv
// Shared types and constants for the memory-bus router and its address decoder.
// MBR_TIMEOUT_WIDTH is the minimum wait-counter width used when MEM_BUS_TIMEOUT_EN is defined.
package mem_bus_router_pkg;

  localparam int RISCV_ADDR_WIDTH  = 32;
  localparam int RISCV_WORD_WIDTH  = 32;
  localparam int MBR_TIMEOUT_WIDTH = 8;
  localparam logic [RISCV_WORD_WIDTH-1:0] MBR_ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    MBR_IDLE = 2'd0,
    MBR_BUSY = 2'd1,
    MBR_ERR  = 2'd2
  } mbr_state_e;

  // Counter must hold TIMEOUT_CYCLES-1; width is clamped to 8..16 bits.
  function automatic int mbr_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    if (w < MBR_TIMEOUT_WIDTH) w = MBR_TIMEOUT_WIDTH;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Combinational address decoder: select field -> {mapped, idx}; also used by the instruction-side router.
// An address is mapped only when the select field is below NUM_TARGETS and all bits above it are zero.
module mem_bus_addr_decode
  import mem_bus_router_pkg::*;
#(
  parameter int NUM_TARGETS = 3,
  parameter int SEL_LSB     = 11,
  parameter int SEL_WIDTH   = 2
) (
  input  logic [RISCV_ADDR_WIDTH-1:0] addr,
  output logic                        mapped,
  output logic [SEL_WIDTH-1:0]        idx
);

  logic [RISCV_ADDR_WIDTH-1:0] shifted;

  assign shifted = addr >> SEL_LSB;
  assign idx     = shifted[SEL_WIDTH-1:0];
  assign mapped  = ((shifted >> SEL_WIDTH) == '0) && (32'(idx) < 32'(NUM_TARGETS));

endmodule

// File: rtl/mem_bus_router.sv
// 1 -> NUM_TARGETS memory-bus router: 0-wait combinational path, held selection while BUSY, error for unmapped.
// Optional MEM_BUS_TIMEOUT_EN adds a BUSY wait counter that forces an error completion after TIMEOUT_CYCLES.
module mem_bus_router
  import mem_bus_router_pkg::*;
#(
  parameter int NUM_TARGETS    = 3,
  parameter int SEL_LSB        = 11,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_valid_i,
  output logic                                    s_ready_o,
  output logic                                    s_err_o,
  input  logic [RISCV_ADDR_WIDTH-1:0]             s_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0]             s_wdata_i,
  input  logic [3:0]                              s_we_i,
  output logic [RISCV_WORD_WIDTH-1:0]             s_rdata_o,
  output logic [NUM_TARGETS-1:0]                  m_valid_o,
  input  logic [NUM_TARGETS-1:0]                  m_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0]             m_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0]             m_wdata_o,
  output logic [3:0]                              m_we_o,
  input  logic [NUM_TARGETS*RISCV_WORD_WIDTH-1:0] m_rdata_i
);

  mbr_state_e                  state_q, state_d;
  logic [SEL_WIDTH-1:0]        idx_q, idx_d, cur_idx, dec_idx;
  logic                        dec_mapped, route;
  logic [NUM_TARGETS-1:0]      tgt_onehot;
  logic                        tgt_ready;
  logic [RISCV_WORD_WIDTH-1:0] tgt_rdata;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = mbr_cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timed_out;
  assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the counter TIMEOUT_CYCLES has no effect; keep it referenced.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  mem_bus_addr_decode #(
    .NUM_TARGETS(NUM_TARGETS),
    .SEL_LSB    (SEL_LSB),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_decode (
    .addr  (s_addr_i),
    .mapped(dec_mapped),
    .idx   (dec_idx)
  );

  assign m_addr_o  = s_addr_i;
  assign m_wdata_o = s_wdata_i;
  assign m_we_o    = s_we_i;

  // While BUSY only the latched target is looked at, whatever the address now decodes to.
  assign cur_idx = (state_q == MBR_BUSY) ? idx_q : dec_idx;

  always_comb begin
    tgt_onehot = '0;
    tgt_ready  = 1'b0;
    tgt_rdata  = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (32'(cur_idx) == k) begin
        tgt_onehot[k] = 1'b1;
        tgt_ready     = m_ready_i[k];
        tgt_rdata     = m_rdata_i[k*RISCV_WORD_WIDTH +: RISCV_WORD_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    route     = 1'b0;
    m_valid_o = '0;
    s_ready_o = 1'b0;
    s_err_o   = 1'b0;
    s_rdata_o = '0;
`ifdef MEM_BUS_TIMEOUT_EN
    wait_cnt_d = '0;
`endif
    if (!rst) begin
      case (state_q)
        MBR_IDLE: begin
          if (s_valid_i) begin
            if (dec_mapped) begin
              route = 1'b1;
              if (!tgt_ready) begin
                state_d = MBR_BUSY;
                idx_d   = dec_idx;
              end
            end else begin
              state_d = MBR_ERR;
            end
          end
        end
        MBR_BUSY: begin
          if (!s_valid_i) begin
            state_d = MBR_IDLE;
          end else begin
            route = 1'b1;
            if (tgt_ready) begin
              state_d = MBR_IDLE;
`ifdef MEM_BUS_TIMEOUT_EN
            end else if (timed_out) begin
              state_d = MBR_ERR;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
          end
        end
        MBR_ERR: begin
          s_ready_o = 1'b1;
          s_err_o   = 1'b1;
          s_rdata_o = MBR_ERR_RDATA;
          state_d   = MBR_IDLE;
        end
        default: state_d = MBR_IDLE;
      endcase
      if (route) begin
        m_valid_o = tgt_onehot;
        s_ready_o = tgt_ready;
        s_rdata_o = tgt_ready ? tgt_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MBR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

endmodule

// File: tb/tb_mem_bus_router.sv
// Scoreboard bench for mem_bus_router: stimulus pushes expected completions, a monitor checks every cycle.
module tb_mem_bus_router;
  import mem_bus_router_pkg::*;

  localparam int NT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid_i, s_ready_o, s_err_o;
  logic [31:0]    s_addr_i, s_wdata_i, s_rdata_o;
  logic [3:0]     s_we_i, m_we_o;
  logic [NT-1:0]  m_valid_o, m_ready_i;
  logic [31:0]    m_addr_o, m_wdata_o;
  logic [NT*32-1:0] m_rdata_i;

  assign m_rdata_i = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

  always #5 clk = ~clk;

  mem_bus_router #(
    .NUM_TARGETS   (NT),
    .SEL_LSB       (11),
    .SEL_WIDTH     (2),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_err_o  (s_err_o),
    .s_addr_i (s_addr_i),
    .s_wdata_i(s_wdata_i),
    .s_we_i   (s_we_i),
    .s_rdata_o(s_rdata_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_addr_o (m_addr_o),
    .m_wdata_o(m_wdata_o),
    .m_we_o   (m_we_o),
    .m_rdata_i(m_rdata_i)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion is matched against the scoreboard; idle outputs must be zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_ready_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ready", 32'(s_ready_o), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("cpl_rdata", s_rdata_o, e.rdata);
          check("cpl_err", 32'(s_err_o), 32'(e.err));
        end
      end else begin
        check("idle_rdata", s_rdata_o, 32'h0);
        check("idle_err", 32'(s_err_o), 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   b2b_addr [4];
    logic [31:0]   b2b_rd   [4];
    logic [NT-1:0] b2b_oh   [4];
    logic [31:0]   err_addr [2];

    b2b_addr = '{32'h0000_0000, 32'h0000_0800, 32'h0000_1000, 32'h0000_0000};
    b2b_rd   = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hAAAA_0000};
    b2b_oh   = '{3'b001, 3'b010, 3'b100, 3'b001};
    err_addr = '{32'h0000_1800, 32'h8000_0000};

    rst = 1'b1; s_valid_i = 1'b0; s_addr_i = '0; s_wdata_i = '0; s_we_i = '0; m_ready_i = '0;
    step(); step();
    #3;
    check("rst_m_valid", 32'(m_valid_o), 32'h0);
    check("rst_s_ready", 32'(s_ready_o), 32'h0);
    step();
    rst = 1'b0;

    // 1: 0-wait read from target 1
    s_valid_i = 1'b1; s_addr_i = 32'h0000_0804; s_we_i = 4'h0; m_ready_i = 3'b010;
    sb_q.push_back('{rdata: 32'hBBBB_0001, err: 1'b0});
    #3;
    check("t1_m_valid", 32'(m_valid_o), 32'(3'b010));
    check("t1_s_ready", 32'(s_ready_o), 32'h1);
    step();
    s_valid_i = 1'b0; m_ready_i = '0;
    step();

    // 2: write to target 2 with 3 wait states; target 0 ready throughout must be ignored
    s_valid_i = 1'b1; s_addr_i = 32'h0000_1000; s_we_i = 4'hF; s_wdata_i = 32'hDEAD_BEEF;
    sb_q.push_back('{rdata: 32'hCCCC_0002, err: 1'b0});
    for (int c = 0; c < 4; c++) begin
      m_ready_i = (c == 3) ? 3'b101 : 3'b001;
      #3;
      check("t2_m_valid", 32'(m_valid_o), 32'(3'b100));
      check("t2_s_ready", 32'(s_ready_o), (c == 3) ? 32'h1 : 32'h0);
      if (c == 0) begin
        check("t2_m_we", 32'(m_we_o), 32'hF);
        check("t2_m_wdata", m_wdata_o, 32'hDEAD_BEEF);
        check("t2_m_addr", m_addr_o, 32'h0000_1000);
      end
      step();
    end
    s_valid_i = 1'b0; m_ready_i = '0; s_we_i = 4'h0;
    step();

    // 3: unmapped select field and nonzero high bit
    for (int i = 0; i < 2; i++) begin
      s_valid_i = 1'b1; s_addr_i = err_addr[i]; m_ready_i = 3'b111;
      sb_q.push_back('{rdata: 32'h0, err: 1'b1});
      #3;
      check("t3_decode_m_valid", 32'(m_valid_o), 32'h0);
      check("t3_decode_s_ready", 32'(s_ready_o), 32'h0);
      step();
      #3;
      check("t3_err_m_valid", 32'(m_valid_o), 32'h0);
      check("t3_err_s_ready", 32'(s_ready_o), 32'h1);
      step();
      s_valid_i = 1'b0; m_ready_i = '0;
      step();
    end

    // 4: target 0 never ready
    s_valid_i = 1'b1; s_addr_i = 32'h0000_0000; m_ready_i = '0;
`ifdef MEM_BUS_TIMEOUT_EN
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
    for (int c = 0; c < 5; c++) begin
      #3;
      check("t4_wait_m_valid", 32'(m_valid_o), 32'(3'b001));
      check("t4_wait_s_ready", 32'(s_ready_o), 32'h0);
      step();
    end
    #3;
    check("t4_to_m_valid", 32'(m_valid_o), 32'h0);
    check("t4_to_s_ready", 32'(s_ready_o), 32'h1);
    step();
    s_valid_i = 1'b0;
    #3;
    check("t4_after_m_valid", 32'(m_valid_o), 32'h0);
    step();
`else
    repeat (100) step();
    #3;
    check("t4_wait100_m_valid", 32'(m_valid_o), 32'(3'b001));
    check("t4_wait100_s_ready", 32'(s_ready_o), 32'h0);
    step();
    s_valid_i = 1'b0;
    step();
`endif

    // 5: reset while BUSY on target 1, then a fresh request that must decode from IDLE
    s_valid_i = 1'b1; s_addr_i = 32'h0000_0800; m_ready_i = '0;
    step();
    #3;
    check("t5_busy_m_valid", 32'(m_valid_o), 32'(3'b010));
    step();
    rst = 1'b1;
    #3;
    check("t5_rst_m_valid", 32'(m_valid_o), 32'h0);
    check("t5_rst_s_ready", 32'(s_ready_o), 32'h0);
    step();
    rst = 1'b0; s_addr_i = 32'h0000_0000; m_ready_i = 3'b011;
    sb_q.push_back('{rdata: 32'hAAAA_0000, err: 1'b0});
    #3;
    check("t5_fresh_m_valid", 32'(m_valid_o), 32'(3'b001));
    check("t5_fresh_s_ready", 32'(s_ready_o), 32'h1);
    step();
    s_valid_i = 1'b0; m_ready_i = '0;
    step();

    // 6: back-to-back 0-wait reads
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1; s_addr_i = b2b_addr[i]; m_ready_i = 3'b111;
      sb_q.push_back('{rdata: b2b_rd[i], err: 1'b0});
      #3;
      check("t6_m_valid", 32'(m_valid_o), 32'(b2b_oh[i]));
      check("t6_s_ready", 32'(s_ready_o), 32'h1);
      step();
    end
    s_valid_i = 1'b0; m_ready_i = '0;
    step(); step();

    check("sb_empty", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
